// File: rtl/fill_trigger_sequencer.sv
// Fill trigger sequencer.
// Accepts a trigger pulse when idle, starts a fill on the enabled digitizer
// channels, waits for every enabled channel to report done (or for the fill
// timeout), writes one header word into the header FIFO, waits for the
// channel readout to finish, then disarms the enabled channels for ARM_LOW
// cycles before returning to idle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   trigger               one-cycle trigger pulse
//   cm_busy               channel manager busy, blocks acceptance
//   chan_en[NCHAN]        channel enable mask, latched at acceptance
//   done[NCHAN]           per-channel fill done (pulse or level)
//   timeout_limit[TMO_W]  fill timeout in cycles, 0 disables it
//   fifo_ready            header FIFO ready
//   chan_readout_done     readout complete pulse
//   fifo_valid, fifo_data header word {timeout_flag, missing_mask, trig_num}
//   go[NCHAN]             per-channel fill start, high through FILL
//   trig_arm[NCHAN]       per-channel arm, enabled channels low during REARM
//   trig_num[TNUM_W]      count of accepted triggers
//   dropped_cnt[16]       saturating count of rejected triggers
//   busy                  high whenever not idle
module fill_trigger_sequencer #(
    parameter int NCHAN   = 5,
    parameter int TNUM_W  = 24,
    parameter int ARM_LOW = 10,
    parameter int TMO_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trigger,
    input  logic                    cm_busy,
    input  logic [NCHAN-1:0]        chan_en,
    input  logic [NCHAN-1:0]        done,
    input  logic [TMO_W-1:0]        timeout_limit,
    input  logic                    fifo_ready,
    input  logic                    chan_readout_done,
    output logic                    fifo_valid,
    output logic [TNUM_W+NCHAN:0]   fifo_data,
    output logic [NCHAN-1:0]        go,
    output logic [NCHAN-1:0]        trig_arm,
    output logic [TNUM_W-1:0]       trig_num,
    output logic [15:0]             dropped_cnt,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        FILL         = 3'd1,
        STORE        = 3'd2,
        WAIT_READOUT = 3'd3,
        REARM        = 3'd4
    } state_t;

    localparam logic [7:0] ARM_LAST = 8'(ARM_LOW - 1);

    state_t              state_q, state_d;
    logic [NCHAN-1:0]    en_q, en_d;
    logic [NCHAN-1:0]    done_seen_q, done_seen_d;
    logic [NCHAN-1:0]    missing_q, missing_d;
    logic                tflag_q, tflag_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [TNUM_W-1:0]   trig_num_q, trig_num_d;
    logic [15:0]         dropped_q, dropped_d;
    logic [7:0]          arm_cnt_q, arm_cnt_d;
    logic [NCHAN-1:0]    go_q, go_d;
    logic [NCHAN-1:0]    trig_arm_q, trig_arm_d;
    logic                fifo_valid_q, fifo_valid_d;
    logic                busy_q, busy_d;
    logic                drop_s;
    logic [NCHAN-1:0]    done_all_s;

    // Done bits seen so far including this cycle's inputs.
    assign done_all_s = done_seen_q | done;

    // Next-state, counters and the registered copies of the outputs.
    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        done_seen_d = done_seen_q;
        missing_d   = missing_q;
        tflag_d     = tflag_q;
        tmo_cnt_d   = tmo_cnt_q;
        trig_num_d  = trig_num_q;
        arm_cnt_d   = arm_cnt_q;
        drop_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    if (!cm_busy && (chan_en != {NCHAN{1'b0}})) begin
                        state_d     = FILL;
                        trig_num_d  = trig_num_q + TNUM_W'(1);
                        en_d        = chan_en;
                        done_seen_d = {NCHAN{1'b0}};
                        missing_d   = {NCHAN{1'b0}};
                        tflag_d     = 1'b0;
                        tmo_cnt_d   = {TMO_W{1'b0}};
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    drop_s = 1'b0;
                end
            end
            FILL: begin
                done_seen_d = done_seen_q | (done & en_q);
                tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
                // Completion is tested first so it wins over a coincident timeout.
                if ((done_all_s & en_q) == en_q) begin
                    state_d   = STORE;
                    tflag_d   = 1'b0;
                    missing_d = {NCHAN{1'b0}};
                end else if ((timeout_limit != {TMO_W{1'b0}}) &&
                             (tmo_cnt_q == (timeout_limit - TMO_W'(1)))) begin
                    state_d   = STORE;
                    tflag_d   = 1'b1;
                    missing_d = en_q & ~done_all_s;
                end else begin
                    state_d = FILL;
                end
            end
            STORE: begin
                if (fifo_valid_q && fifo_ready) begin
                    state_d = WAIT_READOUT;
                end else begin
                    state_d = STORE;
                end
            end
            WAIT_READOUT: begin
                if (chan_readout_done) begin
                    state_d   = REARM;
                    arm_cnt_d = 8'd0;
                end else begin
                    state_d = WAIT_READOUT;
                end
            end
            REARM: begin
                if (arm_cnt_q == ARM_LAST) begin
                    state_d = IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any trigger outside IDLE is rejected.
        if (trigger && (state_q != IDLE)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = drop_s;
        end

        if (drop_s && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end else begin
            dropped_d = dropped_q;
        end

        // Outputs are computed from the next state so they line up with it.
        go_d         = (state_d == FILL)  ? en_d  : {NCHAN{1'b0}};
        trig_arm_d   = (state_d == REARM) ? ~en_d : {NCHAN{1'b1}};
        fifo_valid_d = (state_d == STORE);
        busy_d       = (state_d != IDLE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            en_q         <= {NCHAN{1'b0}};
            done_seen_q  <= {NCHAN{1'b0}};
            missing_q    <= {NCHAN{1'b0}};
            tflag_q      <= 1'b0;
            tmo_cnt_q    <= {TMO_W{1'b0}};
            trig_num_q   <= {TNUM_W{1'b0}};
            dropped_q    <= 16'd0;
            arm_cnt_q    <= 8'd0;
            go_q         <= {NCHAN{1'b0}};
            trig_arm_q   <= {NCHAN{1'b1}};
            fifo_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            done_seen_q  <= done_seen_d;
            missing_q    <= missing_d;
            tflag_q      <= tflag_d;
            tmo_cnt_q    <= tmo_cnt_d;
            trig_num_q   <= trig_num_d;
            dropped_q    <= dropped_d;
            arm_cnt_q    <= arm_cnt_d;
            go_q         <= go_d;
            trig_arm_q   <= trig_arm_d;
            fifo_valid_q <= fifo_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign fifo_valid  = fifo_valid_q;
    assign fifo_data   = {tflag_q, missing_q, trig_num_q};
    assign go          = go_q;
    assign trig_arm    = trig_arm_q;
    assign trig_num    = trig_num_q;
    assign dropped_cnt = dropped_q;
    assign busy        = busy_q;

endmodule
